// File: rtl/ysyx_25020037_lsu.sv
// Load/store stage: accepts one op from execute, issues at most one word-aligned
// memory request, and presents an extended (or faulted) write-back record.
module ysyx_25020037_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              lsu_ready,
  input  logic              is_read,
  input  logic              is_write,
  input  logic [1:0]        mem_size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        rd,
  input  logic              gpr_we,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp_err,
  output logic              lsu_valid,
  input  logic              wbu_ready,
  output logic [3:0]        lsu_rd,
  output logic              lsu_gpr_we,
  output logic [DATA_W-1:0] rdata_processed,
  output logic              lsu_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic       accept;
  logic [1:0] off;
  logic       size_byte;
  logic       size_half;
  logic       is_store;
  logic       is_mem;
  logic       misaligned;
  logic [1:0] accept_tgt;

  logic [3:0]        st_strb;
  logic [DATA_W-1:0] st_data;

  logic [1:0]        off_q;
  logic              byte_q;
  logic              half_q;
  logic              uns_q;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  // Decode of the offered instruction; size 11 falls through to word.
  always_comb begin
    off        = addr[1:0];
    size_byte  = (mem_size == 2'b00);
    size_half  = (mem_size == 2'b01);
    is_store   = is_write;
    is_mem     = is_read | is_write;
    misaligned = is_mem & ((size_half & off[0]) |
                           (!size_byte && !size_half && (off != 2'b00)));
    accept_tgt = (is_mem && !misaligned) ? S_REQ : S_DONE;
  end

  // Byte-lane placement of store data.
  always_comb begin
    st_strb = 4'b1111;
    st_data = wdata;
    if (size_byte) begin
      st_strb = 4'b0001 << off;
      st_data = {4{wdata[7:0]}};
    end else if (size_half) begin
      st_strb = 4'b0011 << off;
      st_data = {2{wdata[15:0]}};
    end
  end

  // Load extraction uses the offset/size captured at accept time.
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_ext  = mem_rdata;
    if (byte_q) begin
      ld_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end else if (half_q) begin
      ld_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake decodes; accept in DONE overrides the drop to IDLE.
  always_comb begin
    state_nxt     = state;
    lsu_ready     = 1'b0;
    mem_req_valid = 1'b0;
    lsu_valid     = 1'b0;
    accept        = 1'b0;
    case (state)
      S_IDLE: lsu_ready = 1'b1;
      S_REQ:  mem_req_valid = 1'b1;
      S_WAIT: ;
      S_DONE: begin
        lsu_valid = 1'b1;
        lsu_ready = wbu_ready;
      end
      default: ;
    endcase
    accept = exu_valid & lsu_ready;
    case (state)
      S_IDLE: if (accept) state_nxt = accept_tgt;
      S_REQ:  if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT: if (mem_resp_valid) state_nxt = S_DONE;
      S_DONE: begin
        if (accept) begin
          state_nxt = accept_tgt;
        end else if (wbu_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request fields and write-back record; only touched on accept or on the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr        <= '0;
      mem_wen         <= 1'b0;
      mem_wdata       <= '0;
      mem_wstrb       <= 4'b0000;
      off_q           <= 2'b00;
      byte_q          <= 1'b0;
      half_q          <= 1'b0;
      uns_q           <= 1'b0;
      lsu_rd          <= 4'd0;
      lsu_gpr_we      <= 1'b0;
      rdata_processed <= '0;
      lsu_fault       <= 1'b0;
    end else if (accept) begin
      mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
      mem_wen   <= is_store;
      mem_wdata <= is_store ? st_data : '0;
      mem_wstrb <= is_store ? st_strb : 4'b0000;
      off_q     <= off;
      byte_q    <= size_byte;
      half_q    <= size_half;
      uns_q     <= load_unsigned;
      lsu_rd    <= rd;
      if (!is_mem) begin
        lsu_gpr_we      <= gpr_we;
        rdata_processed <= DATA_W'(addr);
        lsu_fault       <= 1'b0;
      end else if (misaligned) begin
        lsu_gpr_we      <= 1'b0;
        rdata_processed <= '0;
        lsu_fault       <= 1'b1;
      end else begin
        lsu_gpr_we      <= gpr_we & ~is_store;
        rdata_processed <= '0;
        lsu_fault       <= 1'b0;
      end
    end else if ((state == S_WAIT) && mem_resp_valid) begin
      if (mem_resp_err) begin
        lsu_gpr_we      <= 1'b0;
        rdata_processed <= '0;
        lsu_fault       <= 1'b1;
      end else if (!mem_wen) begin
        rdata_processed <= ld_ext;
      end
    end
  end

endmodule
